// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: instruction field positions, opcode/funct
// constants and the fetch FSM state type.
package cpu_pkg;

    localparam int INSTR_W = 32;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } fd_state_t;

    function automatic logic is_sub(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == OPC_RTYPE) && (funct == FUNCT_SUB);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO buffering fetched {pc, instruction} pairs.
// Flush empties it in one cycle; the head is presented from registered storage.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign valid   = (count != '0);
    assign push_ok = push && (count != DEPTH_C);
    assign pop_ok  = pop && valid;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so stale
    // entries are never observed and the array stays plain RAM without a reset tree.
    always_ff @(posedge clk) begin
        if (push_ok && !flush && !rst) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_decode.sv
// Fetch + field-decode stage: owns the PC, runs the imem req/ack FSM, buffers
// fetched words and slices the buffered head into register-file fields.
module fetch_decode
    import cpu_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [ADDR_W-1:0] dec_pc,
    output logic [5:0]        dec_opcode,
    output logic [4:0]        dec_rs,
    output logic [4:0]        dec_rt,
    output logic [4:0]        dec_rd,
    output logic [5:0]        dec_funct,
    output logic [15:0]       dec_imm,
    output logic              dec_sub
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = ADDR_W + INSTR_W;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    fd_state_t          state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  addr_q;
    logic               req_q;

    logic               fifo_push;
    logic               fifo_pop;
    logic [ENTRY_W-1:0] fifo_head;
    logic               fifo_valid;
    logic [CNT_W-1:0]   fifo_count;
    logic [ADDR_W-1:0]  head_pc;
    logic [31:0]        instr;

    // Acks are only buffered in FETCH; a redirect voids both the push and the pop.
    assign fifo_push = (state == FETCH) && imem_ack && !redirect_valid;
    assign fifo_pop  = fifo_valid && dec_ready && !redirect_valid;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (redirect_valid),
        .din   ({pc, imem_rdata}),
        .head  (fifo_head),
        .valid (fifo_valid),
        .count (fifo_count)
    );

    assign imem_req  = req_q;
    assign imem_addr = addr_q;

    // NOTE: every state register uses non-blocking assignment so all of them
    // update together from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            addr_q <= RESET_PC;
            req_q  <= 1'b0;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
            if (req_q && !imem_ack) begin
                // Bus request cannot be withdrawn: keep it and drop its data later.
                state <= DISCARD;
            end else begin
                state  <= FETCH;
                req_q  <= 1'b1;
                addr_q <= redirect_pc;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_count < DEPTH_C) begin
                        state  <= FETCH;
                        req_q  <= 1'b1;
                        addr_q <= pc;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        pc <= pc + PC_STEP;
                        if (fifo_count + CNT_W'(1) < DEPTH_C) begin
                            addr_q <= pc + PC_STEP;
                        end else begin
                            state <= IDLE;
                            req_q <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        state  <= FETCH;
                        addr_q <= pc;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    assign head_pc = fifo_valid ? fifo_head[ENTRY_W-1:INSTR_W] : '0;
    assign instr   = fifo_valid ? fifo_head[INSTR_W-1:0]       : '0;

    assign dec_valid  = fifo_valid;
    assign dec_pc     = head_pc;
    assign dec_opcode = instr[OPC_HI:OPC_LO];
    assign dec_rs     = instr[RS_HI:RS_LO];
    assign dec_rt     = instr[RT_HI:RT_LO];
    assign dec_rd     = instr[RD_HI:RD_LO];
    assign dec_funct  = instr[FUNCT_HI:FUNCT_LO];
    assign dec_imm    = instr[IMM_HI:IMM_LO];
    assign dec_sub    = fifo_valid && is_sub(dec_opcode, dec_funct);

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: fetch streaming, backpressure, redirect
// handling, PC wrap and mid-request reset, all against hand-computed values.
module tb_fetch_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [5:0]  dec_opcode;
    logic [4:0]  dec_rs;
    logic [4:0]  dec_rt;
    logic [4:0]  dec_rd;
    logic [5:0]  dec_funct;
    logic [15:0] dec_imm;
    logic        dec_sub;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] W_SUB = 32'h0022_1822;
    localparam logic [31:0] W_ADD = 32'h0022_1820;
    localparam logic [31:0] W_LW  = 32'h8C45_0004;

    always #5 clk = ~clk;

    fetch_decode dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_pc         (dec_pc),
        .dec_opcode     (dec_opcode),
        .dec_rs         (dec_rs),
        .dec_rt         (dec_rt),
        .dec_rd         (dec_rd),
        .dec_funct      (dec_funct),
        .dec_imm        (dec_imm),
        .dec_sub        (dec_sub)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        imem_ack       = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: streaming with a SUB word and a ready consumer
        do_reset();
        check("rst_req", imem_req, 0);
        check("rst_valid", dec_valid, 0);
        check("rst_rs", dec_rs, 0);
        check("rst_pc", dec_pc, 0);
        imem_ack = 1'b1; imem_rdata = W_SUB; dec_ready = 1'b1;
        step();
        check("t1_req0", imem_req, 1);
        check("t1_addr0", imem_addr, 32'h0);
        check("t1_novalid", dec_valid, 0);
        step();
        check("t1_valid", dec_valid, 1);
        check("t1_pc0", dec_pc, 32'h0);
        check("t1_rs", dec_rs, 1);
        check("t1_rt", dec_rt, 2);
        check("t1_rd", dec_rd, 3);
        check("t1_sub", dec_sub, 1);
        check("t1_funct", dec_funct, 6'h22);
        check("t1_imm", dec_imm, 16'h1822);
        check("t1_addr4", imem_addr, 32'h4);
        step();
        check("t1_pc4", dec_pc, 32'h4);
        check("t1_req_idle", imem_req, 0);
        step();
        check("t1_req8", imem_req, 1);
        check("t1_addr8", imem_addr, 32'h8);
        check("t1_drained", dec_valid, 0);

        // 2: backpressure fills the buffer and stops fetching
        do_reset();
        imem_ack = 1'b1; imem_rdata = W_SUB;
        step();
        step();
        step();
        check("t2_req_off", imem_req, 0);
        check("t2_valid", dec_valid, 1);
        check("t2_pc", dec_pc, 32'h0);
        step();
        check("t2_req_still_off", imem_req, 0);
        check("t2_pc_stable", dec_pc, 32'h0);
        check("t2_rd_stable", dec_rd, 3);
        dec_ready = 1'b1;
        step();
        check("t2_pc_next", dec_pc, 32'h4);
        check("t2_req_wait", imem_req, 0);
        step();
        check("t2_resume_req", imem_req, 1);
        check("t2_resume_addr", imem_addr, 32'h8);

        // 3: redirect while a request waits for a slow ack
        do_reset();
        dec_ready = 1'b1;
        step();
        imem_ack = 1'b1; imem_rdata = W_SUB;
        step();
        imem_ack = 1'b0;
        step();
        check("t3_pending_addr", imem_addr, 32'h4);
        check("t3_empty_rs", dec_rs, 0);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        check("t3_hold_addr_a", imem_addr, 32'h4);
        check("t3_hold_req_a", imem_req, 1);
        step();
        check("t3_hold_addr_b", imem_addr, 32'h4);
        step();
        check("t3_hold_addr_c", imem_addr, 32'h4);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        check("t3_new_addr", imem_addr, 32'h100);
        check("t3_dropped", dec_valid, 0);
        step();
        check("t3_still_dropped", dec_valid, 0);
        imem_ack = 1'b1; imem_rdata = W_SUB;
        step();
        imem_ack = 1'b0;
        check("t3_target_pc", dec_pc, 32'h100);

        // 4: redirect coinciding with ack and pop
        do_reset();
        step();
        imem_ack = 1'b1; imem_rdata = W_SUB;
        step();
        check("t4_pre_valid", dec_valid, 1);
        imem_rdata = 32'h1111_1111;
        redirect_valid = 1'b1; redirect_pc = 32'h40; dec_ready = 1'b1;
        step();
        redirect_valid = 1'b0; dec_ready = 1'b0;
        check("t4_flushed", dec_valid, 0);
        check("t4_addr", imem_addr, 32'h40);
        imem_rdata = W_ADD;
        step();
        imem_ack = 1'b0;
        check("t4_pc", dec_pc, 32'h40);
        check("t4_add_sub", dec_sub, 0);
        check("t4_add_funct", dec_funct, 6'h20);

        // 5: PC wraps past the top of the address space
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("t5_top_addr", imem_addr, 32'hFFFF_FFFC);
        imem_ack = 1'b1; imem_rdata = W_LW;
        step();
        imem_ack = 1'b0;
        check("t5_wrap_addr", imem_addr, 32'h0);
        check("t5_dec_pc", dec_pc, 32'hFFFF_FFFC);
        check("t5_opcode", dec_opcode, 6'h23);
        check("t5_rt", dec_rt, 5);
        check("t5_imm", dec_imm, 16'h0004);
        check("t5_sub", dec_sub, 0);

        // 6: reset while a request is outstanding, then a stale ack
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_req", imem_req, 0);
        check("t6_valid", dec_valid, 0);
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        step();
        imem_ack = 1'b0;
        check("t6_stale_valid", dec_valid, 0);
        check("t6_restart_req", imem_req, 1);
        check("t6_restart_addr", imem_addr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
